// File: rtl/dma_burst_controller_if.sv
// Bus bundle between the DMA burst engine and its CPU/arbiter/memory/device neighbours.
// master = DMA engine side, slave = system side.
interface dma_burst_controller_if #(
   parameter int WORD_SIZE  = 16,
   parameter int BLOCK_SIZE = 64,
   parameter int IDX_W      = 4
);
   logic                  cmd_valid;
   logic [WORD_SIZE-1:0]  cmd_address;
   logic [WORD_SIZE-1:0]  cmd_length;
   logic                  BR;
   logic                  BG;
   logic                  mem_write;
   logic [WORD_SIZE-1:0]  mem_address;
   logic [BLOCK_SIZE-1:0] mem_data;
   logic                  mem_busy;
   logic [IDX_W-1:0]      dev_index;
   logic [BLOCK_SIZE-1:0] dev_data;
   logic                  cpu_mem_req;
   logic                  dma_busy;
   logic                  dma_end_interrupt;

   modport master (
      input  cmd_valid, cmd_address, cmd_length, BG, mem_busy, dev_data, cpu_mem_req,
      output BR, mem_write, mem_address, mem_data, dev_index, dma_busy, dma_end_interrupt
   );

   modport slave (
      output cmd_valid, cmd_address, cmd_length, BG, mem_busy, dev_data, cpu_mem_req,
      input  BR, mem_write, mem_address, mem_data, dev_index, dma_busy, dma_end_interrupt
   );
endinterface

// File: rtl/dma_burst_controller.sv
// Bus-master DMA: writes a device payload to memory as 64-bit block writes under BR/BG.
// Optional macro DMA_CYCLE_STEAL_EN: yield the bus for one cycle between blocks on cpu_mem_req.
module dma_burst_controller #(
   parameter int WORD_SIZE   = 16,
   parameter int BLOCK_WORDS = 4,
   parameter int BLOCK_SIZE  = 64,
   parameter int IDX_W       = 4
) (
   input logic                    Clk,
   input logic                    Reset_N,
   dma_burst_controller_if.master bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t               state_r;
   state_t               state_s;
   logic [WORD_SIZE-1:0] base_r;
   logic [WORD_SIZE-1:0] blocks_r;
   logic [WORD_SIZE-1:0] pos_r;
   logic                 busy_seen_r;
   logic [WORD_SIZE-1:0] quo_s;
   logic [WORD_SIZE-1:0] rem_s;
   logic [WORD_SIZE-1:0] blocks_s;
   logic                 last_s;
   logic                 wait_exit_s;
   logic                 steal_req_s;
   logic                 steal_hold_s;

`ifdef DMA_CYCLE_STEAL_EN
   logic steal_r;

   // One-cycle marker for the bus-yield REQ cycle between blocks
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         steal_r <= 1'b0;
      end else begin
         steal_r <= (state_r == WAIT) && wait_exit_s && !last_s && steal_req_s;
      end
   end

   assign steal_req_s  = bus.cpu_mem_req;
   assign steal_hold_s = steal_r;
`else
   logic unused_cpu_mem_req_s;
   assign unused_cpu_mem_req_s = bus.cpu_mem_req;
   assign steal_req_s          = 1'b0;
   assign steal_hold_s         = 1'b0;
`endif

   // Ceiling block count; quotient plus a remainder carry cannot overflow the word
   always_comb begin
      quo_s    = bus.cmd_length / WORD_SIZE'(BLOCK_WORDS);
      rem_s    = bus.cmd_length % WORD_SIZE'(BLOCK_WORDS);
      blocks_s = quo_s + {{(WORD_SIZE-1){1'b0}}, (rem_s != {WORD_SIZE{1'b0}})};
   end

   assign last_s      = (pos_r == (blocks_r - WORD_SIZE'(1)));
   assign wait_exit_s = busy_seen_r && !bus.mem_busy;

   // State register
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Transfer context: base, block count, block position, busy-seen flag
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         base_r      <= {WORD_SIZE{1'b0}};
         blocks_r    <= {WORD_SIZE{1'b0}};
         pos_r       <= {WORD_SIZE{1'b0}};
         busy_seen_r <= 1'b0;
      end else begin
         if ((state_r == IDLE) && bus.cmd_valid && (blocks_s != {WORD_SIZE{1'b0}})) begin
            base_r   <= bus.cmd_address;
            blocks_r <= blocks_s;
            pos_r    <= {WORD_SIZE{1'b0}};
         end
         if (state_r == WAIT) begin
            if (wait_exit_s) begin
               busy_seen_r <= 1'b0;
               if (!last_s) begin
                  pos_r <= pos_r + WORD_SIZE'(1);
               end
            end else if (bus.mem_busy) begin
               busy_seen_r <= 1'b1;
            end
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.cmd_valid) begin
               state_s = (blocks_s != {WORD_SIZE{1'b0}}) ? REQ : DONE;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (steal_hold_s) begin
               state_s = REQ;
            end else if (bus.BG) begin
               state_s = ISSUE;
            end else begin
               state_s = REQ;
            end
         end
         ISSUE: begin
            // Losing the grant here returns to REQ without advancing the block
            if (!bus.BG) begin
               state_s = REQ;
            end else if (!bus.mem_busy) begin
               state_s = WAIT;
            end else begin
               state_s = ISSUE;
            end
         end
         WAIT: begin
            if (!wait_exit_s) begin
               state_s = WAIT;
            end else if (last_s) begin
               state_s = DONE;
            end else if (steal_req_s) begin
               state_s = REQ;
            end else begin
               state_s = ISSUE;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      bus.BR                = 1'b0;
      bus.mem_write         = 1'b0;
      bus.dma_end_interrupt = 1'b0;
      bus.dma_busy          = (state_r != IDLE);
      bus.mem_address       = base_r + WORD_SIZE'(pos_r * WORD_SIZE'(BLOCK_WORDS));
      bus.mem_data          = bus.dev_data;
      bus.dev_index         = pos_r[IDX_W-1:0];
      case (state_r)
         IDLE:  bus.BR = 1'b0;
         REQ:   bus.BR = !steal_hold_s;
         ISSUE: begin
            bus.BR        = 1'b1;
            bus.mem_write = bus.BG;
         end
         WAIT:  bus.BR = 1'b1;
         DONE:  bus.dma_end_interrupt = 1'b1;
         default: begin
            bus.BR        = 1'b0;
            bus.mem_write = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dma_burst_controller.sv
// Directed bench for dma_burst_controller: arbiter/memory responder plus hand-computed checks.
module tb_dma_burst_controller;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dma_burst_controller_if #(.WORD_SIZE(16), .BLOCK_SIZE(64), .IDX_W(4)) bus ();

   dma_burst_controller dut (
      .Clk     (clk),
      .Reset_N (rst_n),
      .bus     (bus)
   );

   // Device buffer: block content is a fixed pattern tagged with its index
   assign bus.dev_data = {16'hDA7A, 12'h000, bus.dev_index, 16'hBEEF, 12'hC00, bus.dev_index};

   int total = 0;
   int bad   = 0;

   int grant_delay = 2;
   int busy_cycles = 1;
   int hold_req    = 0;
   int gcnt        = 0;
   int busy_left   = 0;
   int cyc         = 0;
   int wr_cnt      = 0;
   int irq_cnt     = 0;
   int drop_cnt    = 0;
   int mw_cyc      = 0;
   int addr_moved  = 0;
   logic [15:0] wr_addr [0:15];
   logic [3:0]  wr_idx  [0:15];
   logic [63:0] wr_data [0:15];
   int          wr_cyc  [0:15];
   logic [15:0] last_mw_addr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_data(input logic [3:0] i);
      return {16'hDA7A, 12'h000, i, 16'hBEEF, 12'hC00, i};
   endfunction

   // Arbiter grants grant_delay cycles after BR; memory goes busy after each accepted write
   initial begin
      bus.BG       = 1'b0;
      bus.mem_busy = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!bus.BR) begin
            bus.BG = 1'b0;
            gcnt   = 0;
         end else if (gcnt >= grant_delay) begin
            bus.BG = 1'b1;
         end else begin
            gcnt++;
         end
         #1;
         if (busy_left > 0) begin
            bus.mem_busy = 1'b1;
            busy_left--;
         end else if (hold_req > 0 && bus.mem_write) begin
            bus.mem_busy = 1'b1;
            hold_req--;
         end else begin
            bus.mem_busy = 1'b0;
         end
         #1;
         if (bus.mem_write) begin
            if (mw_cyc > 0 && bus.mem_address !== last_mw_addr) addr_moved++;
            last_mw_addr = bus.mem_address;
            mw_cyc++;
         end
         if (bus.mem_write && !bus.mem_busy) begin
            if (wr_cnt < 16) begin
               wr_addr[wr_cnt] = bus.mem_address;
               wr_idx[wr_cnt]  = bus.dev_index;
               wr_data[wr_cnt] = bus.mem_data;
               wr_cyc[wr_cnt]  = cyc;
            end
            wr_cnt++;
            busy_left = busy_cycles;
         end
         if (bus.dma_end_interrupt) irq_cnt++;
         if (bus.dma_busy && !bus.BR && !bus.dma_end_interrupt) drop_cnt++;
      end
   end

   task automatic step();
      @(negedge clk);
      #3;
   endtask

   task automatic clear_log();
      wr_cnt     = 0;
      irq_cnt    = 0;
      drop_cnt   = 0;
      mw_cyc     = 0;
      addr_moved = 0;
   endtask

   task automatic issue(input logic [15:0] a, input logic [15:0] l);
      bus.cmd_address = a;
      bus.cmd_length  = l;
      bus.cmd_valid   = 1'b1;
      step();
      bus.cmd_valid   = 1'b0;
   endtask

   task automatic wait_irq();
      int n = 0;
      while (irq_cnt == 0 && n < 200) begin
         step();
         n++;
      end
      check("irq_seen", 64'(irq_cnt != 0), 64'd1);
      step();
   endtask

   task automatic wait_writes(input int k);
      int n = 0;
      while (wr_cnt < k && n < 200) begin
         step();
         n++;
      end
      check("write_reached", 64'(wr_cnt >= k), 64'd1);
   endtask

   initial begin
      int t0;
      rst_n           = 1'b0;
      bus.cmd_valid   = 1'b0;
      bus.cmd_address = 16'h0000;
      bus.cmd_length  = 16'h0000;
      bus.cpu_mem_req = 1'b0;
      step();
      step();
      check("rst_br",       64'(bus.BR),                64'd0);
      check("rst_mem_write",64'(bus.mem_write),         64'd0);
      check("rst_busy",     64'(bus.dma_busy),          64'd0);
      check("rst_irq",      64'(bus.dma_end_interrupt), 64'd0);
      check("rst_addr",     64'(bus.mem_address),       64'h0000);
      check("rst_idx",      64'(bus.dev_index),         64'd0);
      rst_n = 1'b1;
      step();

      // Three blocks at 0x01F0, grant after 2 cycles, 1-cycle busy
      clear_log();
      issue(16'h01F0, 16'd12);
      t0 = cyc;
      check("t1_br_req",   64'(bus.BR),        64'd1);
      check("t1_busy_req", 64'(bus.dma_busy),  64'd1);
      check("t1_no_write", 64'(bus.mem_write), 64'd0);
      wait_irq();
      check("t1_wr_cnt",   64'(wr_cnt),     64'd3);
      check("t1_addr0",    64'(wr_addr[0]), 64'h01F0);
      check("t1_addr1",    64'(wr_addr[1]), 64'h01F4);
      check("t1_addr2",    64'(wr_addr[2]), 64'h01F8);
      check("t1_idx0",     64'(wr_idx[0]),  64'd0);
      check("t1_idx1",     64'(wr_idx[1]),  64'd1);
      check("t1_idx2",     64'(wr_idx[2]),  64'd2);
      check("t1_data1",    wr_data[1],      exp_data(4'd1));
      check("t1_grant_lat",64'(wr_cyc[0] - t0),        64'd3);
      check("t1_blk_lat",  64'(wr_cyc[1] - wr_cyc[0]), 64'd3);
      check("t1_irq_1cyc", 64'(irq_cnt),   64'd1);
      check("t1_no_drop",  64'(drop_cnt),  64'd0);
      check("t1_idle",     64'(bus.dma_busy), 64'd0);
      check("t1_br_low",   64'(bus.BR),       64'd0);

      // Length 5 rounds up to two blocks
      clear_log();
      issue(16'h0000, 16'd5);
      wait_irq();
      check("t2_wr_cnt", 64'(wr_cnt),     64'd2);
      check("t2_addr0",  64'(wr_addr[0]), 64'h0000);
      check("t2_addr1",  64'(wr_addr[1]), 64'h0004);

      // Zero length: straight to DONE; a strobe during DONE is ignored
      clear_log();
      issue(16'h0040, 16'd0);
      check("t3_irq",      64'(bus.dma_end_interrupt), 64'd1);
      check("t3_no_br",    64'(bus.BR),                64'd0);
      bus.cmd_address = 16'h0000;
      bus.cmd_length  = 16'd4;
      bus.cmd_valid   = 1'b1;
      step();
      bus.cmd_valid   = 1'b0;
      check("t3_ignored",  64'(bus.dma_busy), 64'd0);
      step();
      check("t3_still_idle", 64'(bus.dma_busy), 64'd0);
      check("t3_no_write",   64'(wr_cnt),       64'd0);
      check("t3_irq_cnt",    64'(irq_cnt),      64'd1);

      // Address wrap past 0xFFFF
      grant_delay = 0;
      clear_log();
      issue(16'hFFF8, 16'd16);
      wait_irq();
      check("t4_wr_cnt", 64'(wr_cnt),     64'd4);
      check("t4_addr0",  64'(wr_addr[0]), 64'hFFF8);
      check("t4_addr1",  64'(wr_addr[1]), 64'hFFFC);
      check("t4_addr2",  64'(wr_addr[2]), 64'h0000);
      check("t4_addr3",  64'(wr_addr[3]), 64'h0004);
      check("t4_idx3",   64'(wr_idx[3]),  64'd3);

      // Memory busy for 3 issue cycles: write held, one acceptance
      clear_log();
      hold_req = 3;
      issue(16'h0100, 16'd4);
      wait_irq();
      check("t5_wr_cnt",   64'(wr_cnt),     64'd1);
      check("t5_mw_cyc",   64'(mw_cyc),     64'd4);
      check("t5_addr_stb", 64'(addr_moved), 64'd0);
      check("t5_addr",     64'(wr_addr[0]), 64'h0100);

      // Asynchronous reset in WAIT of block 1
      busy_cycles = 3;
      clear_log();
      issue(16'h0200, 16'd8);
      wait_writes(2);
      step();
      rst_n = 1'b0;
      #1;
      check("t6_br",    64'(bus.BR),        64'd0);
      check("t6_mw",    64'(bus.mem_write), 64'd0);
      check("t6_busy",  64'(bus.dma_busy),  64'd0);
      check("t6_idx",   64'(bus.dev_index), 64'd0);
      step();
      step();
      step();
      check("t6_no_irq", 64'(irq_cnt), 64'd0);
      rst_n = 1'b1;
      busy_cycles = 1;
      step();
      step();
      clear_log();
      issue(16'h0300, 16'd4);
      wait_irq();
      check("t6_restart_cnt",  64'(wr_cnt),     64'd1);
      check("t6_restart_idx",  64'(wr_idx[0]),  64'd0);
      check("t6_restart_addr", 64'(wr_addr[0]), 64'h0300);

      // CPU request after block 0 of 3
      grant_delay = 1;
      clear_log();
      issue(16'h0400, 16'd12);
      wait_writes(1);
      bus.cpu_mem_req = 1'b1;
      wait_writes(2);
      bus.cpu_mem_req = 1'b0;
      wait_irq();
      check("t7_wr_cnt", 64'(wr_cnt),     64'd3);
      check("t7_addr2",  64'(wr_addr[2]), 64'h0408);
      check("t7_idx1",   64'(wr_idx[1]),  64'd1);
      check("t7_idx2",   64'(wr_idx[2]),  64'd2);
      check("t7_irq",    64'(irq_cnt),    64'd1);
`ifdef DMA_CYCLE_STEAL_EN
      check("t7_br_drop", 64'(drop_cnt), 64'd1);
`else
      check("t7_br_drop", 64'(drop_cnt), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
